// File: rtl/vc_arbiter.sv
// vc_arbiter: moves words from two virtual-channel input FIFOs (VC0, VC1)
// to two destination FIFOs (D0, D1). VC0 has strict priority, capped by a
// starvation guard that hands VC1 a slot after MAX_CONSEC_VC0 VC0 grants.
// Each word is steered by its DEST_BIT through a two-stage pipeline:
// pop -> source capture -> registered destination push.
module vc_arbiter #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int DEST_BIT       = 8,
    parameter int MAX_CONSEC_VC0 = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [FIFO_WORD_SIZE-1:0] vc0_data_out,
    input  logic [FIFO_WORD_SIZE-1:0] vc1_data_out,
    input  logic                      vc0_empty,
    input  logic                      vc1_empty,
    input  logic                      d0_almost_full,
    input  logic                      d1_almost_full,
    input  logic                      fifo_error,
    output logic                      vc0_rd_en,
    output logic                      vc1_rd_en,
    output logic                      d0_wr_en,
    output logic                      d1_wr_en,
    output logic [FIFO_WORD_SIZE-1:0] d_data_in,
    output logic [CNT_WIDTH-1:0]      d0_count,
    output logic [CNT_WIDTH-1:0]      d1_count,
    output logic [1:0]                state,
    output logic                      idle
);

    localparam int CW = $clog2(MAX_CONSEC_VC0 + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        STALL  = 2'b10,
        ERROR  = 2'b11
    } state_t;

    state_t                    st, st_nxt;
    logic [CW-1:0]             consec;
    logic                      guard;
    logic                      any_in;
    logic                      any_af;
    logic                      p1_valid;
    logic                      p1_src;
    logic [FIFO_WORD_SIZE-1:0] sel_data;

    assign any_in   = !vc0_empty || !vc1_empty;
    assign any_af   = d0_almost_full || d1_almost_full;
    assign guard    = (consec == CW'(MAX_CONSEC_VC0));
    // The popped word stays on the source's data_out until that source pops again.
    assign sel_data = p1_src ? vc1_data_out : vc0_data_out;
    assign state    = st;
    assign idle     = (st == IDLE) && !p1_valid && !d0_wr_en && !d1_wr_en;

    // FSM state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) st <= IDLE;
        else          st <= st_nxt;
    end

    // FSM next state; fifo_error overrides everything and ERROR is sticky
    always_comb begin
        st_nxt = st;
        if (fifo_error) begin
            st_nxt = ERROR;
        end else begin
            case (st)
                IDLE:    if (any_in) st_nxt = any_af ? STALL : ACTIVE;
                ACTIVE:  if (any_af) st_nxt = STALL;
                         else if (!any_in) st_nxt = IDLE;
                STALL:   if (!any_af) st_nxt = any_in ? ACTIVE : IDLE;
                default: st_nxt = ERROR;
            endcase
        end
    end

    // Grant: almost-full gates pops in the same cycle so at most two words
    // are ever in flight toward a destination that has signalled pressure.
    always_comb begin
        vc0_rd_en = 1'b0;
        vc1_rd_en = 1'b0;
        if (st == ACTIVE && !any_af) begin
            if (guard)           vc1_rd_en = !vc1_empty;
            else if (!vc0_empty) vc0_rd_en = 1'b1;
            else                 vc1_rd_en = !vc1_empty;
        end
    end

    // Starvation counter: VC0 grants made while VC1 is waiting
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)                   consec <= '0;
        else if (vc1_empty || vc1_rd_en) consec <= '0;
        else if (vc0_rd_en)             consec <= consec + 1'b1;
    end

    // Stage 1: remember that a pop happened and which source it came from
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            p1_valid <= 1'b0;
            p1_src   <= 1'b0;
        end else begin
            p1_valid <= vc0_rd_en || vc1_rd_en;
            p1_src   <= vc1_rd_en;
        end
    end

    // Stage 2: registered push to the destination picked by DEST_BIT, plus counters
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0_wr_en  <= 1'b0;
            d1_wr_en  <= 1'b0;
            d_data_in <= '0;
            d0_count  <= '0;
            d1_count  <= '0;
        end else begin
            d0_wr_en <= p1_valid && !sel_data[DEST_BIT];
            d1_wr_en <= p1_valid &&  sel_data[DEST_BIT];
            if (p1_valid) begin
                d_data_in <= sel_data;
                if (sel_data[DEST_BIT]) d1_count <= d1_count + 1'b1;
                else                    d0_count <= d0_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: behavioural input FIFOs, a scoreboard of expected
// destination writes (data, destination, pop-to-write latency) and
// directed sequences for reset, routing, priority/guard, backpressure,
// error, mid-stream reset and counter wrap.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [9:0] vc0_data_out = '0;
    logic [9:0] vc1_data_out = '0;
    logic       vc0_empty, vc1_empty;
    logic       d0_almost_full, d1_almost_full, fifo_error;
    logic       vc0_rd_en, vc1_rd_en, d0_wr_en, d1_wr_en;
    logic [9:0] d_data_in;
    logic [7:0] d0_count, d1_count;
    logic [1:0] state;
    logic       idle;

    always #5 clk = ~clk;

    vc_arbiter dut (
        .clk(clk), .reset_L(reset_L),
        .vc0_data_out(vc0_data_out), .vc1_data_out(vc1_data_out),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .fifo_error(fifo_error),
        .vc0_rd_en(vc0_rd_en), .vc1_rd_en(vc1_rd_en),
        .d0_wr_en(d0_wr_en), .d1_wr_en(d1_wr_en),
        .d_data_in(d_data_in), .d0_count(d0_count), .d1_count(d1_count),
        .state(state), .idle(idle)
    );

    // input FIFO models: bench writes wp at negedge, pops happen at posedge
    logic [9:0] vc0_mem [64];
    logic [9:0] vc1_mem [64];
    logic [5:0] vc0_wp = '0, vc0_rp = '0, vc1_wp = '0, vc1_rp = '0;
    assign vc0_empty = (vc0_wp == vc0_rp);
    assign vc1_empty = (vc1_wp == vc1_rp);

    always @(posedge clk) begin
        if (vc0_rd_en) begin
            vc0_data_out <= vc0_mem[vc0_rp];
            vc0_rp       <= vc0_rp + 6'd1;
        end
        if (vc1_rd_en) begin
            vc1_data_out <= vc1_mem[vc1_rp];
            vc1_rp       <= vc1_rp + 6'd1;
        end
    end

    // scoreboard state
    logic [9:0] exp_q [$];
    int         pop_cyc [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_d0 = '0;
    logic [7:0] exp_d1 = '0;
    logic [9:0] w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push0(input logic [9:0] d);
        vc0_mem[vc0_wp] = d;
        vc0_wp = vc0_wp + 6'd1;
    endtask

    task automatic push1(input logic [9:0] d);
        vc1_mem[vc1_wp] = d;
        vc1_wp = vc1_wp + 6'd1;
    endtask

    task automatic expect_word(input logic [9:0] d);
        exp_q.push_back(d);
        if (d[8]) exp_d1 = exp_d1 + 8'd1;
        else      exp_d0 = exp_d0 + 8'd1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        exp_q.delete();
        pop_cyc.delete();
        exp_d0 = '0;
        exp_d1 = '0;
        vc0_wp = vc0_rp;
        vc1_wp = vc1_rp;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(idle && exp_q.size() == 0), 1);
    endtask

    task automatic chk_counts(input string tag);
        chk(tag, 32'({d0_count, d1_count}), 32'({exp_d0, exp_d1}));
    endtask

    // pop timestamps for the latency check
    always @(posedge clk) begin
        if (reset_L && (vc0_rd_en || vc1_rd_en)) pop_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    // output monitor: every destination write must match the next expected word
    always @(negedge clk) begin
        if (reset_L) begin
            chk("rd_excl", 32'(vc0_rd_en & vc1_rd_en), 0);
            if (d0_wr_en || d1_wr_en) begin
                chk("wr_excl", 32'(d0_wr_en & d1_wr_en), 0);
                if (exp_q.size() == 0) begin
                    chk("unexp_wr", 32'(d_data_in), 32'h400);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_data", 32'(d_data_in), 32'(w));
                    chk("wr_dest", 32'(d1_wr_en), 32'(w[8]));
                end
                if (pop_cyc.size() == 0) chk("wr_no_pop", 1, 0);
                else                     chk("wr_lat", 32'(cyc - pop_cyc.pop_front()), 2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        reset_L = 1'b0; d0_almost_full = 1'b0; d1_almost_full = 1'b0; fifo_error = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_rd", 32'({vc0_rd_en, vc1_rd_en}), 0);
        chk("rst_wr", 32'({d0_wr_en, d1_wr_en}), 0);
        chk("rst_data", 32'(d_data_in), 0);
        chk("rst_cnt", 32'({d0_count, d1_count}), 0);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_rd", 32'({vc0_rd_en, vc1_rd_en}), 0);

        // routing by DEST_BIT
        push0(10'h001); push0(10'h100);
        expect_word(10'h001); expect_word(10'h100);
        repeat (2) @(negedge clk);
        wait_idle(20, "route_drain");
        chk_counts("route_cnt");

        // priority with starvation guard: VC0 x4, VC1, VC0 x4, VC1 x2
        for (int i = 0; i < 8; i++) push0({1'b0, i[0], 8'(8'h10 + i)});
        for (int j = 0; j < 3; j++) push1({2'b11, 8'(8'hB0 + j)});
        for (int i = 0; i < 4; i++) expect_word({1'b0, i[0], 8'(8'h10 + i)});
        expect_word({2'b11, 8'hB0});
        for (int i = 4; i < 8; i++) expect_word({1'b0, i[0], 8'(8'h10 + i)});
        expect_word({2'b11, 8'hB1});
        expect_word({2'b11, 8'hB2});
        repeat (2) @(negedge clk);
        wait_idle(40, "prio_drain");
        chk_counts("prio_cnt");

        // backpressure mid-stream
        for (int i = 0; i < 6; i++) begin
            push0({1'b0, i[0], 8'(8'h40 + i)});
            expect_word({1'b0, i[0], 8'(8'h40 + i)});
        end
        repeat (3) @(negedge clk);
        d1_almost_full = 1'b1;
        #1 chk("bp_no_rd_same", 32'({vc0_rd_en, vc1_rd_en}), 0);
        @(negedge clk);
        chk("bp_state", 32'(state), 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_rd", 32'({vc0_rd_en, vc1_rd_en}), 0);
            chk("bp_hold_state", 32'(state), 2);
        end
        chk("bp_inflight", 32'(exp_q.size()), 4);
        chk("bp_vc0_kept", 32'(vc0_empty), 0);
        d1_almost_full = 1'b0;
        @(negedge clk);
        chk("bp_resume", 32'(state), 1);
        wait_idle(30, "bp_drain");
        chk_counts("bp_cnt");

        // error pulse while ACTIVE: the pop granted in the error cycle still lands
        for (int i = 0; i < 4; i++) push0({2'b01, 8'(8'h60 + i)});
        for (int i = 0; i < 3; i++) expect_word({2'b01, 8'(8'h60 + i)});
        repeat (3) @(negedge clk);
        fifo_error = 1'b1;
        @(negedge clk);
        fifo_error = 1'b0;
        chk("err_state", 32'(state), 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("err_rd", 32'({vc0_rd_en, vc1_rd_en}), 0);
            chk("err_sticky", 32'(state), 3);
        end
        chk("err_flushed", 32'(exp_q.size()), 0);
        chk("err_vc0_left", 32'(vc0_empty), 0);
        chk_counts("err_cnt");
        do_reset();
        #1 chk("err_rst_state", 32'(state), 0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        // reset mid-stream with a word in stage 1
        for (int i = 0; i < 4; i++) push0({1'b0, i[0], 8'(8'h70 + i)});
        expect_word({2'b00, 8'h70});
        expect_word({2'b01, 8'h71});
        repeat (4) @(negedge clk);
        #2 chk_counts("mid_cnt_pre");
        do_reset();
        #1;
        chk("mid_wr", 32'({d0_wr_en, d1_wr_en}), 0);
        chk("mid_cnt", 32'({d0_count, d1_count}), 0);
        chk("mid_state", 32'(state), 0);
        chk("mid_rd", 32'({vc0_rd_en, vc1_rd_en}), 0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_no_wr", 32'({d0_wr_en, d1_wr_en}), 0);
            chk("mid_idle", 32'(idle), 1);
        end

        // counter wrap: 260 words to D0 leaves d0_count at 4
        for (int i = 0; i < 260; i++) begin
            push0({2'b00, 8'(i)});
            expect_word({2'b00, 8'(i)});
            @(negedge clk);
        end
        wait_idle(50, "wrap_drain");
        chk_counts("wrap_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Transaction-layer arbiter between two virtual-channel input FIFOs (VC0, VC1) and two destination output FIFOs (D0, D1), all instances of the team's parameterised FIFO. It pops words from VC0 with strict priority, bounded by a starvation guard for VC1, and routes each word to D0 or D1 by a destination bit in the word. It stalls on destination almost-full backpressure and counts the words delivered per destination.

## Interface
- FIFO_WORD_SIZE, 10, width of every data word.
- DEST_BIT, 8, bit index selecting the destination: 0 → D0, 1 → D1.
- MAX_CONSEC_VC0, 4, maximum consecutive VC0 grants while VC1 is non-empty.
- CNT_WIDTH, 8, width of the delivered-word counters.

- clk  in  1  single clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- vc0_data_out, vc1_data_out  in  FIFO_WORD_SIZE each  input FIFO read data.
- vc0_empty, vc1_empty  in  1 each  input FIFO empty flags.
- d0_almost_full, d1_almost_full  in  1 each  destination almost-full flags.
- fifo_error  in  1  OR of all four FIFO error_flag outputs.
- vc0_rd_en, vc1_rd_en  out  1 each  combinational pop strobes.
- d0_wr_en, d1_wr_en  out  1 each  registered push strobes.
- d_data_in  out  FIFO_WORD_SIZE  registered write data, shared by D0 and D1.
- d0_count, d1_count  out  CNT_WIDTH each  words delivered per destination; wrap modulo 2^CNT_WIDTH.
- state  out  2  FSM state: IDLE=00, ACTIVE=01, STALL=10, ERROR=11.
- idle  out  1  high when state==IDLE and both pipeline stages are empty.

## Operation
- Input FIFO contract: a pop happens at the edge where rd_en is high; data_out holds the popped word from that edge until the next pop.
- Grant, combinational, evaluated only when state==ACTIVE, d0_almost_full=0 and d1_almost_full=0:
  - vc0_rd_en=1 if VC0 is non-empty, unless the starvation guard is active.
  - vc1_rd_en=1 if VC0 is empty, or if the guard is active and VC1 is non-empty.
  - vc0_rd_en and vc1_rd_en are never high together.
- Starvation guard:
  - consec counter increments on each VC0 grant while VC1 is non-empty.
  - It clears on any VC1 grant, and whenever VC1 is empty.
  - The guard is active when consec==MAX_CONSEC_VC0.
- Pipeline stage 1, at the pop edge: register p1_valid=1 and p1_src (0=VC0, 1=VC1).
- Pipeline stage 2, at the next edge:
  - d_data_in ← selected source data_out.
  - d0_wr_en or d1_wr_en ← p1_valid, steered by that word's DEST_BIT.
  - The matching dX_count increments by 1 at the same edge.
- FSM transitions; fifo_error has highest priority from every state:
  - IDLE → ACTIVE when any input is non-empty and no destination is almost-full.
  - IDLE → STALL when any input is non-empty and a destination is almost-full.
  - ACTIVE → STALL when any almost-full flag is high.
  - ACTIVE → IDLE when both inputs are empty.
  - STALL → ACTIVE when both almost-full flags are low and an input is non-empty.
  - STALL → IDLE when both almost-full flags are low and both inputs are empty.
  - any state → ERROR when fifo_error=1. ERROR is sticky until reset; no new grants; words already in the pipeline still complete.
- Almost-full is also gated combinationally into the grant, so no pop occurs in the cycle a flag rises.
- Up to 2 words can be in flight. Integration therefore requires ALMOST_FULL_THRESHOLD ≤ FIFO_DEPTH-2 (6 of 8 satisfies this), which guarantees no destination overflow.

## Timing
- Reset (reset_L low, asynchronous): state=IDLE; all rd_en and wr_en low; d_data_in=0; counters=0; consec=0; p1_valid=0; idle=1. Pipeline contents are discarded.
- Latency: pop at edge k → dX_wr_en high and d_data_in valid after edge k+1 → destination FIFO writes at edge k+2.
- Throughput: one word per cycle in ACTIVE.
- A grant first appears in the cycle after the edge at which the FSM enters ACTIVE.
- Reset asserted mid-transfer: outputs clear immediately; in-flight words are lost.
- Counter at 2^CNT_WIDTH-1 plus one delivery wraps to 0.

## Test plan
- Reset: hold reset_L=0 for 2 cycles → all outputs 0, state=00, idle=1. Release reset → outputs stay idle with both inputs empty.
- Routing: push 0x001 and 0x100 into VC0 → d0_wr_en with d_data_in=0x001, then d1_wr_en with 0x100, each 2 edges after its pop. Final counts d0_count=1, d1_count=1.
- Priority and guard: preload VC0 with 8 words and VC1 with 3 words, then enable → grant order VC0×4, VC1, VC0×4, VC1×2.
- Backpressure: raise d1_almost_full mid-stream → no rd_en in the same cycle; state=STALL next edge; ≤2 in-flight writes complete. Lower the flag → ACTIVE, and streaming resumes.
- Error: pulse fifo_error while ACTIVE → state=11 next edge; rd_en stays 0; in-flight words still written; state remains 11 until reset_L=0.
- Reset mid-stream: assert reset_L=0 with p1_valid=1 → wr_en, counters and state clear immediately; no write appears after reset is released.
